// File: rtl/mips_multicycle_control.sv
// Main control FSM for a multicycle MIPS datapath: sequences fetch/decode/execute
// over several cycles and drives the datapath control lines, stalling on mem_ready.
module mips_multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   state_t r_state;
   state_t w_state_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   assign state = r_state;

   // Next-state logic; unused codes 12..15 fall into the default and recover to FETCH.
   always_comb begin
      w_state_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_state_next = S_MEMADR;
               OP_RTYPE:     w_state_next = S_EXEC;
               OP_BEQ:       w_state_next = S_BRANCH;
               OP_J:         w_state_next = S_JUMP;
               OP_ADDI:      w_state_next = S_ADDIEX;
               default:      w_state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_SW) begin
               w_state_next = S_MEMWR;
            end else if (opcode == OP_LW) begin
               w_state_next = S_MEMRD;
            end else begin
               w_state_next = S_FETCH;
            end
         end
         S_MEMRD:  w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_state_next = S_FETCH;
         S_MEMWR:  w_state_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_state_next = S_ALUWB;
         S_ALUWB:  w_state_next = S_FETCH;
         S_BRANCH: w_state_next = S_FETCH;
         S_JUMP:   w_state_next = S_FETCH;
         S_ADDIEX: w_state_next = S_ADDIWB;
         S_ADDIWB: w_state_next = S_FETCH;
         default:  w_state_next = S_FETCH;
      endcase
   end

   logic w_opcode_known;

   always_comb begin
      case (opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_opcode_known = 1'b1;
         default:                                       w_opcode_known = 1'b0;
      endcase
   end

   // Moore output decode; only FETCH's pc/ir load and illegal_op look at inputs.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      case (r_state)
         S_DECODE: begin
            alu_src_b  = SRCB_IMM4;
            illegal_op = ~w_opcode_known;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         default: begin
            // FETCH and the unreachable codes share the fetch decode.
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class,
// stalls, an illegal opcode and a mid-stall reset, checking state and controls per cycle.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state;

   int n_total = 0;
   int n_pass  = 0;

   mips_multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
   //  reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], illegal_op}
   logic [16:0] ctrl;
   assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

   localparam logic [16:0] E_FETCH_RDY   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [16:0] E_FETCH_STALL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] E_DECODE      = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] E_DECODE_ILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
   localparam logic [16:0] E_MEMADR      = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] E_MEMRD       = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] E_MEMWB       = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [16:0] E_MEMWR       = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] E_EXEC        = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] E_ALUWB       = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [16:0] E_BRANCH      = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [16:0] E_JUMP        = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

   task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Check state and controls of the current cycle, then advance one clock.
   task automatic step(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_ctrl);
      #1;
      chk({tag, ".state"}, {13'd0, state}, {13'd0, exp_state});
      chk({tag, ".ctrl"}, ctrl, exp_ctrl);
      $display("step %-12s state=%0d ctrl=%b", tag, state, ctrl);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      opcode = 6'b000000;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      step("reset", 4'd0, E_FETCH_STALL);

      // R-type; mem_ready dropped outside FETCH must not matter
      reset = 1'b0;
      mem_ready = 1'b1;
      opcode = 6'b000000;
      step("r_fetch", 4'd0, E_FETCH_RDY);
      mem_ready = 1'b0;
      step("r_decode", 4'd1, E_DECODE);
      step("r_exec", 4'd6, E_EXEC);
      step("r_aluwb", 4'd7, E_ALUWB);
      mem_ready = 1'b1;

      // lw with a 3-cycle MEMRD stall
      opcode = 6'b100011;
      step("lw_fetch", 4'd0, E_FETCH_RDY);
      step("lw_decode", 4'd1, E_DECODE);
      step("lw_memadr", 4'd2, E_MEMADR);
      mem_ready = 1'b0;
      step("lw_stall1", 4'd3, E_MEMRD);
      step("lw_stall2", 4'd3, E_MEMRD);
      step("lw_stall3", 4'd3, E_MEMRD);
      mem_ready = 1'b1;
      step("lw_memrd", 4'd3, E_MEMRD);
      step("lw_memwb", 4'd4, E_MEMWB);

      // sw, beq, j back to back
      opcode = 6'b101011;
      step("sw_fetch", 4'd0, E_FETCH_RDY);
      step("sw_decode", 4'd1, E_DECODE);
      step("sw_memadr", 4'd2, E_MEMADR);
      step("sw_memwr", 4'd5, E_MEMWR);
      opcode = 6'b000100;
      step("beq_fetch", 4'd0, E_FETCH_RDY);
      step("beq_decode", 4'd1, E_DECODE);
      step("beq_branch", 4'd8, E_BRANCH);
      opcode = 6'b000010;
      step("j_fetch", 4'd0, E_FETCH_RDY);
      step("j_decode", 4'd1, E_DECODE);
      step("j_jump", 4'd9, E_JUMP);

      // addi
      opcode = 6'b001000;
      step("ad_fetch", 4'd0, E_FETCH_RDY);
      step("ad_decode", 4'd1, E_DECODE);
      step("ad_ex", 4'd10, E_MEMADR);
      step("ad_wb", 4'd11, 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0);

      // FETCH stall for 2 cycles, then illegal opcode in DECODE
      mem_ready = 1'b0;
      step("f_stall1", 4'd0, E_FETCH_STALL);
      step("f_stall2", 4'd0, E_FETCH_STALL);
      mem_ready = 1'b1;
      step("f_ready", 4'd0, E_FETCH_RDY);
      opcode = 6'b111111;
      step("ill_decode", 4'd1, E_DECODE_ILL);
      opcode = 6'b000000;
      mem_ready = 1'b0;
      step("ill_after", 4'd0, E_FETCH_STALL);

      // reset while stalled in MEMRD
      mem_ready = 1'b1;
      opcode = 6'b100011;
      step("rs_fetch", 4'd0, E_FETCH_RDY);
      step("rs_decode", 4'd1, E_DECODE);
      step("rs_memadr", 4'd2, E_MEMADR);
      mem_ready = 1'b0;
      step("rs_stall", 4'd3, E_MEMRD);
      reset = 1'b1;
      step("rs_memrd", 4'd3, E_MEMRD);
      step("rs_reset", 4'd0, E_FETCH_STALL);
      reset = 1'b0;
      mem_ready = 1'b1;
      opcode = 6'b000000;
      step("rs_fetch2", 4'd0, E_FETCH_RDY);
      step("rs_decode2", 4'd1, E_DECODE);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
